// File: rtl/matrix_pkg.sv
// Shared types and width helpers for the BCM matrix scanner and its OE timer.
package matrix_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StShift,
    StWait,
    StBlankPre,
    StLatch,
    StBlankPost
  } scan_state_e;

  // Counter width for a value range 0..n-1, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned col_width(input int unsigned columns);
    return idx_width(columns);
  endfunction

  function automatic int unsigned slot_cycles(input int unsigned pixel_half);
    return 2 * pixel_half;
  endfunction

  // Wide enough to hold the longest on-time, OE_BASE_CYCLES << (BRIGHTNESS_BITS-1).
  function automatic int unsigned timer_width(input int unsigned base, input int unsigned bits);
    return $clog2(base << (bits - 1)) + 1;
  endfunction

endpackage

// File: rtl/bcm_oe_timer.sv
// Output-enable on-time down-counter: plane k stays lit for OE_BASE_CYCLES << k cycles.
module bcm_oe_timer
  import matrix_pkg::*;
#(
  parameter int unsigned OE_BASE_CYCLES  = 4,
  parameter int unsigned BRIGHTNESS_BITS = 6
) (
  input  logic                                  clk_in,
  input  logic                                  reset,
  input  logic                                  load,
  input  logic [idx_width(BRIGHTNESS_BITS)-1:0] plane,
  output logic                                  output_enable,
  output logic                                  expired
);

  localparam int unsigned TW = timer_width(OE_BASE_CYCLES, BRIGHTNESS_BITS);

  logic [TW-1:0] count_q, count_d;
  logic [TW-1:0] load_val;

  always_comb begin
    load_val = TW'(OE_BASE_CYCLES) << plane;
    count_d  = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign output_enable = (count_q != '0);
  // True when OE is already low or drops on the coming edge, so blanking starts right after.
  assign expired = (count_q <= TW'(1));

  load_only_when_idle: assert property (@(posedge clk_in) disable iff (reset)
    load |-> (count_q == '0));

endmodule

// File: rtl/matrix_scan_bcm.sv
// HUB75-style scan controller: column/row addressing, pixel clock, latch and OE using
// pipelined binary-coded modulation (the next bit-plane shifts while the current one shows).
module matrix_scan_bcm
  import matrix_pkg::*;
#(
  parameter int unsigned COLUMNS         = 64,
  parameter int unsigned ROW_ADDR_WIDTH  = 4,
  parameter int unsigned BRIGHTNESS_BITS = 6,
  parameter int unsigned OE_BASE_CYCLES  = 4,
  parameter int unsigned BLANK_CYCLES    = 2,
  parameter int unsigned PIXEL_HALF      = 1
) (
  input  logic                          clk_in,
  input  logic                          reset,
  input  logic                          enable,
  output logic [col_width(COLUMNS)-1:0] column_address,
  output logic [ROW_ADDR_WIDTH-1:0]     row_address,
  output logic [ROW_ADDR_WIDTH-1:0]     row_address_active,
  output logic [BRIGHTNESS_BITS-1:0]    brightness_mask,
  output logic                          pixel_load_start,
  output logic                          clk_pixel,
  output logic                          row_latch,
  output logic                          output_enable,
  output logic                          frame_start
);

  localparam int unsigned COL_W       = col_width(COLUMNS);
  localparam int unsigned SLOT_CYCLES = slot_cycles(PIXEL_HALF);
  localparam int unsigned PHASE_W     = idx_width(SLOT_CYCLES);
  localparam int unsigned PLANE_W     = idx_width(BRIGHTNESS_BITS);
  localparam int unsigned BLANK_W     = idx_width(BLANK_CYCLES);

  localparam logic [COL_W-1:0]   LAST_COL   = COL_W'(COLUMNS - 1);
  localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(SLOT_CYCLES - 1);
  localparam logic [PHASE_W-1:0] HALF       = PHASE_W'(PIXEL_HALF);
  localparam logic [BLANK_W-1:0] LAST_BLANK = BLANK_W'(BLANK_CYCLES - 1);
  localparam logic [PLANE_W-1:0] LAST_PLANE = PLANE_W'(BRIGHTNESS_BITS - 1);

  scan_state_e               state_q, state_d;
  logic [COL_W-1:0]          col_q, col_d;
  logic [PHASE_W-1:0]        phase_q, phase_d;
  logic [BLANK_W-1:0]        blank_q, blank_d;
  logic [ROW_ADDR_WIDTH-1:0] row_q, row_d;
  logic [ROW_ADDR_WIDTH-1:0] row_active_q, row_active_d;
  logic [PLANE_W-1:0]        plane_q, plane_d;
  logic [PLANE_W-1:0]        disp_plane_q, disp_plane_d;

  logic timer_load;
  logic oe_expired;

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    phase_d      = phase_q;
    blank_d      = blank_q;
    row_d        = row_q;
    row_active_d = row_active_q;
    plane_d      = plane_q;
    disp_plane_d = disp_plane_q;
    timer_load   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (enable) begin
          state_d = StShift;
        end
      end

      StShift: begin
        if (phase_q == LAST_PHASE) begin
          phase_d = '0;
          if (col_q == LAST_COL) begin
            col_d   = '0;
            state_d = StWait;
          end else begin
            col_d = col_q + 1'b1;
          end
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end

      // The previous plane must finish its on-time before the new one is latched.
      StWait: begin
        if (oe_expired) begin
          state_d = StBlankPre;
        end
      end

      StBlankPre: begin
        if (blank_q == LAST_BLANK) begin
          blank_d = '0;
          state_d = StLatch;
        end else begin
          blank_d = blank_q + 1'b1;
        end
      end

      StLatch: begin
        row_active_d = row_q;
        disp_plane_d = plane_q;
        state_d      = StBlankPost;
        if (plane_q == LAST_PLANE) begin
          plane_d = '0;
          row_d   = row_q + 1'b1;
        end else begin
          plane_d = plane_q + 1'b1;
        end
      end

      StBlankPost: begin
        if (blank_q == LAST_BLANK) begin
          blank_d    = '0;
          timer_load = 1'b1;
          state_d    = enable ? StShift : StIdle;
        end else begin
          blank_d = blank_q + 1'b1;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      col_q        <= '0;
      phase_q      <= '0;
      blank_q      <= '0;
      row_q        <= '0;
      row_active_q <= '0;
      plane_q      <= '0;
      disp_plane_q <= '0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      phase_q      <= phase_d;
      blank_q      <= blank_d;
      row_q        <= row_d;
      row_active_q <= row_active_d;
      plane_q      <= plane_d;
      disp_plane_q <= disp_plane_d;
    end
  end

  bcm_oe_timer #(
    .OE_BASE_CYCLES (OE_BASE_CYCLES),
    .BRIGHTNESS_BITS(BRIGHTNESS_BITS)
  ) u_oe_timer (
    .clk_in       (clk_in),
    .reset        (reset),
    .load         (timer_load),
    .plane        (disp_plane_q),
    .output_enable(output_enable),
    .expired      (oe_expired)
  );

  // Strobes decode straight from registered state so async reset clears them at once.
  assign column_address     = col_q;
  assign row_address        = row_q;
  assign row_address_active = row_active_q;
  assign brightness_mask    = BRIGHTNESS_BITS'(1) << plane_q;
  assign pixel_load_start   = (state_q == StShift) && (phase_q == '0);
  assign clk_pixel          = (state_q == StShift) && (phase_q >= HALF);
  assign row_latch          = (state_q == StLatch);
  assign frame_start        = pixel_load_start && (col_q == '0) && (row_q == '0) &&
                              (plane_q == '0);

  no_oe_during_latch: assert property (@(posedge clk_in) disable iff (reset)
    row_latch |-> !output_enable);

  mask_one_hot: assert property (@(posedge clk_in) disable iff (reset)
    $onehot(brightness_mask));

  column_in_range: assert property (@(posedge clk_in) disable iff (reset)
    column_address <= LAST_COL);

endmodule

// File: tb/tb_matrix_scan_bcm.sv
// Randomised-enable bench for matrix_scan_bcm: a timeline model predicts every output each cycle.
module tb_matrix_scan_bcm;

  localparam int C    = 4;
  localparam int RW   = 2;
  localparam int B    = 3;
  localparam int BASE = 16;
  localparam int BL   = 1;
  localparam int PH   = 1;
  localparam int R    = 1 << RW;
  localparam int SLOT = 2 * PH;
  localparam int S    = C * SLOT;

  logic clk_in = 1'b0;
  logic reset  = 1'b1;
  logic enable = 1'b0;

  logic [1:0] col_a, row_a, act_a, col_b, row_b, act_b;
  logic [2:0] mask_a, mask_b;
  logic       pls_a, cp_a, rl_a, oe_a, fs_a;
  logic       pls_b, cp_b, rl_b, oe_b, fs_b;

  always #5 clk_in = ~clk_in;

  matrix_scan_bcm #(
    .COLUMNS(C), .ROW_ADDR_WIDTH(RW), .BRIGHTNESS_BITS(B),
    .OE_BASE_CYCLES(BASE), .BLANK_CYCLES(BL), .PIXEL_HALF(PH)
  ) dut (
    .clk_in(clk_in), .reset(reset), .enable(enable),
    .column_address(col_a), .row_address(row_a), .row_address_active(act_a),
    .brightness_mask(mask_a), .pixel_load_start(pls_a), .clk_pixel(cp_a),
    .row_latch(rl_a), .output_enable(oe_a), .frame_start(fs_a)
  );

  // Short-plane variant: on-time of plane 0 is a single cycle.
  matrix_scan_bcm #(
    .COLUMNS(C), .ROW_ADDR_WIDTH(RW), .BRIGHTNESS_BITS(B),
    .OE_BASE_CYCLES(1), .BLANK_CYCLES(BL), .PIXEL_HALF(PH)
  ) dut_short (
    .clk_in(clk_in), .reset(reset), .enable(enable),
    .column_address(col_b), .row_address(row_b), .row_address_active(act_b),
    .brightness_mask(mask_b), .pixel_load_start(pls_b), .clk_pixel(cp_b),
    .row_latch(rl_b), .output_enable(oe_b), .frame_start(fs_b)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Model per instance: active job start t0, OE window [oon, ooff), latches completed nl.
  int md[2], t0[2], oon[2], ooff[2], nl[2];
  int base_c[2] = '{BASE, 1};

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Blanking starts once both the shift (plus one wait cycle) and the old on-time are over.
  function automatic int latch_at(input int i);
    int bp;
    bp = t0[i] + S + 1;
    if (ooff[i] > bp) bp = ooff[i];
    return bp + BL;
  endfunction

  task automatic model_step(input int i);
    if (reset) begin
      md[i] = 0; t0[i] = 0; oon[i] = 0; ooff[i] = 0; nl[i] = 0;
    end else if (md[i] == 1) begin
      int l;
      l = latch_at(i);
      if (cyc == l + 1) nl[i]++;
      if (cyc == l + BL + 1) begin
        oon[i]  = cyc;
        ooff[i] = cyc + (base_c[i] << ((nl[i] - 1) % B));
        if (enable) t0[i] = cyc;
        else md[i] = 0;
      end
    end else if (enable) begin
      md[i] = 1;
      t0[i] = cyc;
    end
  endtask

  task automatic check_inst(input int i, input string p, input int col, input int row,
                            input int act, input int mask, input int pls, input int cp,
                            input int rl, input int oe, input int fs);
    int off, e_col, e_pls, e_cp, e_fs;
    bit shifting;
    shifting = (md[i] == 1) && (cyc >= t0[i]) && (cyc < t0[i] + S);
    off   = cyc - t0[i];
    e_col = shifting ? off / SLOT : 0;
    e_pls = (shifting && (off % SLOT == 0)) ? 1 : 0;
    e_cp  = (shifting && (off % SLOT >= PH)) ? 1 : 0;
    e_fs  = (e_pls == 1 && off == 0 && (nl[i] % (B * R)) == 0) ? 1 : 0;
    chk({p, ".column_address"}, col, e_col);
    chk({p, ".row_address"}, row, (nl[i] / B) % R);
    chk({p, ".row_address_active"}, act, (nl[i] == 0) ? 0 : ((nl[i] - 1) / B) % R);
    chk({p, ".brightness_mask"}, mask, 1 << (nl[i] % B));
    chk({p, ".pixel_load_start"}, pls, e_pls);
    chk({p, ".clk_pixel"}, cp, e_cp);
    chk({p, ".row_latch"}, rl, (md[i] == 1 && cyc == latch_at(i)) ? 1 : 0);
    chk({p, ".output_enable"}, oe, (cyc >= oon[i] && cyc < ooff[i]) ? 1 : 0);
    chk({p, ".frame_start"}, fs, e_fs);
  endtask

  // Event history used by the hand-computed checks.
  int   first_fs = -1, first_rl = -1, pls_first = 0;
  int   run_a = 0, run_b = 0;
  int   runs_a[$], runs_b[$], act_q[$];
  logic rl_prev = 1'b0;

  always @(posedge clk_in) begin
    #1;
    cyc++;
    model_step(0);
    model_step(1);
    check_inst(0, "main", col_a, row_a, act_a, mask_a, pls_a, cp_a, rl_a, oe_a, fs_a);
    check_inst(1, "short", col_b, row_b, act_b, mask_b, pls_b, cp_b, rl_b, oe_b, fs_b);
    if (reset) begin
      first_fs = -1; first_rl = -1; pls_first = 0; run_a = 0; run_b = 0;
      runs_a.delete(); runs_b.delete(); act_q.delete(); rl_prev = 1'b0;
    end else begin
      if (fs_a && first_fs < 0) first_fs = cyc;
      if (rl_a && first_rl < 0) first_rl = cyc;
      if (pls_a && first_rl < 0) pls_first++;
      if (oe_a) run_a++;
      else if (run_a > 0) begin runs_a.push_back(run_a); run_a = 0; end
      if (oe_b) run_b++;
      else if (run_b > 0) begin runs_b.push_back(run_b); run_b = 0; end
      if (rl_prev) act_q.push_back(int'(act_a));
      rl_prev = rl_a;
    end
  end

  int exp_act[13] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};
  int exp_run_a[3] = '{16, 32, 64};
  int exp_run_b[3] = '{1, 2, 4};

  initial begin
    int found;
    reset  = 1'b1;
    enable = 1'b0;
    repeat (3) @(negedge clk_in);
    enable = 1'b1;
    reset  = 1'b0;
    repeat (700) @(negedge clk_in);

    chk("first_latch_offset", first_rl - first_fs, 10);
    chk("first_shift_loads", pls_first, 4);
    chk("oe_runs_main_count", (runs_a.size() >= 3) ? 3 : runs_a.size(), 3);
    chk("oe_runs_short_count", (runs_b.size() >= 3) ? 3 : runs_b.size(), 3);
    for (int k = 0; k < 3; k++) begin
      if (runs_a.size() > k) chk($sformatf("oe_run_main[%0d]", k), runs_a[k], exp_run_a[k]);
      if (runs_b.size() > k) chk($sformatf("oe_run_short[%0d]", k), runs_b[k], exp_run_b[k]);
    end
    chk("active_seq_count", (act_q.size() >= 13) ? 13 : act_q.size(), 13);
    for (int k = 0; k < 13; k++) begin
      if (act_q.size() > k) chk($sformatf("row_active_after_latch[%0d]", k), act_q[k], exp_act[k]);
    end

    // Random enable pattern, including drops mid-shift and long idle gaps.
    for (int seg = 0; seg < 60; seg++) begin
      @(negedge clk_in);
      enable = ($urandom_range(0, 3) != 0);
      repeat ($urandom_range(1, 120)) @(negedge clk_in);
    end

    // Async reset while shifting with OE lit.
    @(negedge clk_in);
    enable = 1'b1;
    found  = 0;
    for (int w = 0; w < 2000 && found == 0; w++) begin
      @(posedge clk_in);
      #1;
      if (pls_a && oe_a && col_a != 2'd0) found = 1;
    end
    chk("areset_wait_shift_with_oe", found, 1);
    if (found == 1) begin
      #2;
      reset = 1'b1;
      #1;
      chk("areset.column_address", col_a, 0);
      chk("areset.row_address", row_a, 0);
      chk("areset.row_address_active", act_a, 0);
      chk("areset.brightness_mask", mask_a, 1);
      chk("areset.pixel_load_start", pls_a, 0);
      chk("areset.clk_pixel", cp_a, 0);
      chk("areset.row_latch", rl_a, 0);
      chk("areset.output_enable", oe_a, 0);
      chk("areset.frame_start", fs_a, 0);
      repeat (3) @(negedge clk_in);
      reset = 1'b0;
    end

    repeat (400) @(negedge clk_in);
    for (int seg = 0; seg < 20; seg++) begin
      enable = ($urandom_range(0, 1) != 0);
      repeat ($urandom_range(1, 200)) @(negedge clk_in);
    end
    enable = 1'b0;
    repeat (300) @(negedge clk_in);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/matrix_scan_bcm.md
Name: matrix_scan_bcm

Overview:
- Parametrised successor to the fixed 64x32, 6-bit matrix scanner.
- Generates column/row addressing, pixel clock, row latch, output enable and a one-hot brightness plane select for a HUB75-style panel.
- Uses pipelined binary-coded modulation: the next bit-plane is shifted in while the current one is displayed.
- Sits between the framebuffer fetch and pixel split blocks. Panel geometry, colour depth, OE weighting and blanking are all parameters.

Parameters:
COLUMNS, 64, pixels shifted per scan line (>=2).
ROW_ADDR_WIDTH, 4, scan-row address width; rows = 2**ROW_ADDR_WIDTH.
BRIGHTNESS_BITS, 6, bit-planes per row (>=1).
OE_BASE_CYCLES, 4, OE on-time of plane 0 in clk_in cycles; plane k lasts OE_BASE_CYCLES<<k.
BLANK_CYCLES, 2, OE-low dead time before and after each latch (>=1).
PIXEL_HALF, 1, clk_in cycles per pixel-clock half period (>=1).

Ports:
clk_in  in  1  system clock
reset  in  1  asynchronous, active-high reset
enable  in  1  run scanning; when low, stop after the current plane
column_address  out  $clog2(COLUMNS)  column being fetched/shifted
row_address  out  ROW_ADDR_WIDTH  row being shifted (fetch side)
row_address_active  out  ROW_ADDR_WIDTH  row currently driven/displayed
brightness_mask  out  BRIGHTNESS_BITS  one-hot plane being shifted
pixel_load_start  out  1  one-cycle pulse at the start of each column slot
clk_pixel  out  1  panel shift clock
row_latch  out  1  one-cycle latch strobe
output_enable  out  1  active-high display enable (inverted at the pin by the top level)
frame_start  out  1  one-cycle pulse when shifting of row 0, plane 0 begins

Behaviour:
- Reset values: all outputs 0; brightness_mask = 1 (plane 0); state IDLE.
- FSM states: IDLE, SHIFT, WAIT, BLANK_PRE, LATCH, BLANK_POST.
- IDLE:
  - Enters SHIFT when enable=1.
  - Pulses frame_start in the first SHIFT cycle whenever row_address=0 and brightness_mask=1.
- SHIFT column slot: 2*PIXEL_HALF cycles per column.
  - pixel_load_start=1 in the slot's first cycle only.
  - clk_pixel=0 for the first PIXEL_HALF cycles and 1 for the last PIXEL_HALF cycles.
  - column_address is constant for the whole slot and increments 0..COLUMNS-1.
  - After the last slot, clk_pixel returns to 0 and the FSM goes to WAIT.
- OE timer (independent down-counter):
  - Loaded with OE_BASE_CYCLES<<k when output_enable rises for plane k.
  - output_enable=1 while the count is nonzero.
  - When the count reaches 0, output_enable drops on the same edge.
- WAIT: leaves for BLANK_PRE when the OE timer has expired. If the timer is already 0, this takes 1 cycle.
- BLANK_PRE: BLANK_CYCLES cycles with output_enable=0.
- LATCH (1 cycle):
  - row_latch=1.
  - row_address_active <= row_address; the displayed plane index <= the current plane.
  - Advance the shift plane: mask rotates left.
  - On wrap from the MSB plane, mask returns to 1 and row_address increments modulo 2**ROW_ADDR_WIDTH (wraps to 0).
- BLANK_POST:
  - BLANK_CYCLES cycles with output_enable=0, then load the OE timer for the latched plane.
  - Go to SHIFT if enable=1, else IDLE.
  - In IDLE, output_enable stays 0 once the final plane's timer expires.
- Simultaneous events:
  - If the timer expires on the same edge that SHIFT completes, WAIT lasts 1 cycle.
  - The first plane after reset is displayed with the timer at 0. The first latch therefore occurs directly after the first shift, plus 1 WAIT cycle.
- Throughput: a short plane whose on-time is less than the shift time leaves OE low until the shift completes. This is accepted; the BCM ratio is exact only when OE_BASE_CYCLES >= 2*PIXEL_HALF*COLUMNS.
- Asynchronous reset mid-operation: all outputs return immediately to their reset values, including output_enable=0 and row_latch=0.
- Width rules:
  - Timer width is $clog2(OE_BASE_CYCLES<<(BRIGHTNESS_BITS-1))+1.
  - The column counter compares against COLUMNS-1, so non-power-of-two column counts are allowed.

Decomposition:
- Shared package matrix_pkg: state enum; localparams COL_W = $clog2(COLUMNS), SLOT_CYCLES = 2*PIXEL_HALF, and the timer width function.
- One sub-module, bcm_oe_timer, takes load, plane index, OE_BASE_CYCLES and BRIGHTNESS_BITS, and outputs output_enable and expired.
- The FSM and counters stay in matrix_scan_bcm.

Test Plan:
(Parameters for all scenarios: COLUMNS=4, ROW_ADDR_WIDTH=2, BRIGHTNESS_BITS=3, OE_BASE_CYCLES=16, BLANK_CYCLES=1, PIXEL_HALF=1.)
- Reset release with enable=1:
  - frame_start pulses once.
  - Exactly 4 pixel_load_start pulses, 2 cycles apart, with column_address 0,1,2,3.
  - 4 clk_pixel rising edges.
  - row_latch at cycle 8+1+1=10 after SHIFT start.
- OE widths: after the latch of planes 0, 1 and 2, output_enable high runs are 16, 32 and 64 cycles, each preceded and followed by exactly 1 OE-low cycle around row_latch.
- Row sequencing over 12 latches: row_address_active steps 0,0,0,1,1,1,2,2,2,3,3,3; the 13th latch yields 0; frame_start pulses every 12 latches.
- enable deasserted mid-shift: the current shift and latch complete, OE runs its full width, then output_enable=0 and no further pixel_load_start pulses; re-asserting enable resumes at the next plane/row without skipping.
- Async reset asserted while output_enable=1 and the FSM is in SHIFT: all outputs are 0 within the same cycle, without waiting for a clock edge; brightness_mask=1 afterwards.
- With OE_BASE_CYCLES=1 (short plane), plane 0 OE is high for 1 cycle, then OE stays low until SHIFT ends; no OE overlaps row_latch.
